// File: rtl/alu_exec_stage.sv
// Execute stage around an external combinational ALU: issue slot (S1) feeding the ALU,
// result slot (S2) toward writeback, plus the architectural {CR, OV, NG, ZR} status register.
module alu_exec_stage #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]  in_b,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_setf,
  output logic [DATA_W-1:0]  alu_ina,
  output logic [DATA_W-1:0]  alu_inb,
  output logic [3:0]         alu_op,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_cr,
  input  logic               alu_ov,
  input  logic               alu_ng,
  input  logic               alu_zr,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [DATA_W-1:0]  wb_data,
  output logic [RADDR_W-1:0] wb_rd,
  output logic               wb_err,
  output logic [3:0]         flags
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 4;

  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_LS  = 4'b0011;
  localparam logic [OP_W-1:0] OP_SRS = 4'b0100;
  localparam logic [OP_W-1:0] OP_URS = 4'b0101;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT = 4'b0111;
  localparam logic [OP_W-1:0] OP_RRO = 4'b1000;
  localparam logic [OP_W-1:0] OP_LRO = 4'b1001;

  logic               s1_valid;
  logic [DATA_W-1:0]  s1_a;
  logic [DATA_W-1:0]  s1_b;
  logic [OP_W-1:0]    s1_op;
  logic [RADDR_W-1:0] s1_rd;
  logic               s1_setf;

  logic s2_free;
  logic s1_adv;
  logic in_fire;
  logic s1_legal;
  logic s1_arith;

  // Opcode classification of the op currently sitting in S1
  always_comb begin
    s1_legal = 1'b0;
    s1_arith = 1'b0;
    case (s1_op)
      OP_ADD, OP_SUB: begin
        s1_legal = 1'b1;
        s1_arith = 1'b1;
      end
      OP_AND, OP_OR, OP_SLT, OP_LS, OP_URS, OP_SRS, OP_RRO, OP_LRO: s1_legal = 1'b1;
      default: s1_legal = 1'b0;
    endcase
  end

  // Handshake; flush blocks acceptance so in_ready never depends on in_valid
  always_comb begin
    s2_free  = !wb_valid || wb_ready;
    s1_adv   = s1_valid && s2_free;
    in_ready = !flush && (!s1_valid || s1_adv);
    in_fire  = in_valid && in_ready;
  end

  assign alu_ina = s1_a;
  assign alu_inb = s1_b;
  assign alu_op  = s1_op;

  // S1 issue register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_rd    <= '0;
      s1_setf  <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_op    <= in_op;
      s1_rd    <= in_rd;
      s1_setf  <= in_setf;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 result register; illegal opcodes report an error with a zero result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      wb_err   <= 1'b0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else if (s1_adv) begin
      wb_valid <= 1'b1;
      wb_data  <= s1_legal ? alu_out : '0;
      wb_rd    <= s1_rd;
      wb_err   <= !s1_legal;
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

  // Status register commits on the same edge that loads S2; CR/OV only from ADD/SUB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= FLAG_W'(0);
    end else if (!flush && s1_adv && s1_setf && s1_legal) begin
      flags[1] <= alu_ng;
      flags[0] <= alu_zr;
      if (s1_arith) begin
        flags[3] <= alu_cr;
        flags[2] <= alu_ov;
      end
    end
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage wrapper around the combinational ALU: a two-slot pipeline with valid/ready handshakes on both sides.
- Slot S1 (issue register) latches decoded operands and opcode from the decoder and drives the ALU inputs directly.
- Slot S2 (result register) captures ALU result and flags for the writeback stage.
- Owns the architectural status register {CR, OV, NG, ZR}.

Parameters:
- DATA_W, 8, operand/result width.
- RADDR_W, 3, destination register address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  decoder presents an op.
- in_ready  output  1  stage accepts the op this cycle.
- in_op  input  4  ALU opcode: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, LS 0011, URS 0101, SRS 0100, RRO 1000, LRO 1001.
- in_a, in_b  input  DATA_W  operands.
- in_rd  input  RADDR_W  destination register.
- in_setf  input  1  op updates status flags.
- alu_ina, alu_inb  output  DATA_W  to ALU; equal to S1 operands.
- alu_op  output  4  to ALU; equal to S1 opcode.
- alu_out  input  DATA_W  ALU result.
- alu_cr, alu_ov, alu_ng, alu_zr  input  1  ALU flags.
- wb_valid  output  1  S2 holds a result.
- wb_ready  input  1  writeback consumes S2.
- wb_data  output  DATA_W  registered result.
- wb_rd  output  RADDR_W  registered destination.
- wb_err  output  1  op was an illegal opcode.
- flags  output  4  status register {CR, OV, NG, ZR}.

Behaviour:
- Reset (rst_n low, asynchronous):
  - s1_valid = 0, wb_valid = 0.
  - wb_data = 0, wb_rd = 0, wb_err = 0.
  - flags = 4'b0000.
  - alu_ina, alu_inb and alu_op read 0.
- Reset deasserting mid-operation: in-flight ops are discarded; no flag update.
- Handshake:
  - Transfer occurs on (valid & ready) at the rising edge.
  - Once wb_valid is asserted, wb_data, wb_rd and wb_err are held stable until wb_ready.
- Stage advances:
  - s2_free = !wb_valid | wb_ready.
  - s1_adv = s1_valid & s2_free.
  - in_ready = !s1_valid | s1_adv.
  - in_ready is combinational from wb_ready; there is no combinational path from in_valid.
- Throughput: one op per cycle when wb_ready stays high. Latency is 2 cycles from input acceptance to wb_valid.
- On s1_adv, S2 captures:
  - wb_data = alu_out and wb_rd = S1 rd.
  - wb_err = 1 if the S1 opcode is not one of the ten legal codes. In that case wb_data = 0 and flags are untouched.
- Flag update: happens on s1_adv when S1 setf = 1 and the opcode is legal.
  - NG and ZR always update, from alu_ng and alu_zr.
  - CR and OV update only for ADD and SUB, from alu_cr and alu_ov; for all other ops they retain their value.
- Flag timing: flags change in the same edge that loads S2, so they are visible one cycle before writeback consumes the result.
- Simultaneous cases:
  - S2 consumed and S1 advancing in the same cycle: S2 reloads with no bubble.
  - S1 advancing and a new input accepted in the same cycle: S1 reloads with no bubble.
- Backpressure: while wb_ready is low and both slots are full, in_ready = 0 and S1 holds. The ALU inputs stay stable, so alu_out stays stable.
- Flush (synchronous, highest priority after reset):
  - s1_valid and wb_valid clear at the next edge.
  - An op at the input in that cycle is not accepted: in_ready is forced to 0 during flush.
  - Flags keep their value; no flag update occurs in the flush cycle.
- Data registers are not cleared on flush; only the valid bits are.

Test Plan:
- Reset mid-stream: ops in both slots, pull rst_n low asynchronously -> wb_valid = 0, in_ready = 1, flags = 0000 immediately; the held op never appears.
- ADD with setf: a = 8'hFF, b = 8'h01, wb_ready = 1 -> wb_valid two cycles later, wb_data = 00, flags CR = 1, ZR = 1, NG = 0, OV = 0.
- Following AND with setf: a = 8'h80, b = 8'hF0 -> wb_data = 80, NG = 1, ZR = 0, CR = 1 retained, OV retained.
- Backpressure: stream 4 ADDs while wb_ready is held low for 3 cycles:
  - in_ready drops after 2 ops accepted.
  - wb_data stays stable during the stall.
  - All 4 results arrive in order with no loss or duplication.
- Illegal opcode 4'b1111 with setf = 1 -> wb_err = 1, wb_data = 00, flags unchanged.
- Flush with both slots full and in_valid high -> next cycle wb_valid = 0, s1 empty, the offered op is not accepted, flags unchanged; the next op after flush completes normally.
